// File: rtl/vga_pixel_out.sv
// rtl/vga_pixel_out.sv - VGA timing generator and FIFO read-side pixel pipeline (optional VGA_UNDERFLOW_CNT_EN)
module vga_pixel_out #(
    parameter int RGB_W     = 12,
    parameter int H_DISPLAY = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter bit SYNC_POL  = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    output logic             fifo_read,
    input  logic [RGB_W-1:0] fifo_dout,
    input  logic             fifo_empty,
    output logic             vga_hsync,
    output logic             vga_vsync,
    output logic [RGB_W-1:0] vga_rgb,
    output logic             frame_start,
    output logic             underflow
`ifdef VGA_UNDERFLOW_CNT_EN
    ,
    output logic [15:0]      underflow_cnt
`endif
);

    localparam int H_TOTAL = H_DISPLAY + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_DISPLAY + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST  = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST  = VW'(V_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT   = HW'(H_DISPLAY);
    localparam logic [VW-1:0] V_ACT   = VW'(V_DISPLAY);
    localparam logic [HW-1:0] HS_BEG  = HW'(H_DISPLAY + H_FP);
    localparam logic [HW-1:0] HS_END  = HW'(H_DISPLAY + H_FP + H_SYNC - 1);
    localparam logic [VW-1:0] VS_BEG  = VW'(V_DISPLAY + V_FP);
    localparam logic [VW-1:0] VS_END  = VW'(V_DISPLAY + V_FP + V_SYNC - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RUN} state_t;

    state_t          state, state_next;
    logic [HW-1:0]   h_cnt;
    logic [VW-1:0]   v_cnt;
    logic            active, hs_raw, vs_raw, last_pix, uf_event;
    logic            active_d, hs_d, vs_d, read_issued_d;

    assign active   = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    assign hs_raw   = (h_cnt >= HS_BEG) && (h_cnt <= HS_END);
    assign vs_raw   = (v_cnt >= VS_BEG) && (v_cnt <= VS_END);
    assign last_pix = (h_cnt == H_LAST) && (v_cnt == V_LAST);
    assign uf_event = (state == RUN) && active && fifo_empty;

    assign frame_start = (state != IDLE) && (h_cnt == '0) && (v_cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Entry to RUN waits for a frame boundary so the first pop is pixel (0,0).
    always_comb begin
        state_next = state;
        fifo_read  = 1'b0;
        case (state)
            IDLE: if (enable) state_next = WAIT;
            WAIT: begin
                if (!enable)                       state_next = IDLE;
                else if (last_pix && !fifo_empty)  state_next = RUN;
            end
            RUN: begin
                fifo_read = active && !fifo_empty;
                if (!enable) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (state == IDLE || !enable) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

    // Stage 1 lines up with the FIFO's registered dout; stage 2 drives the pins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_d      <= 1'b0;
            hs_d          <= 1'b0;
            vs_d          <= 1'b0;
            read_issued_d <= 1'b0;
            vga_hsync     <= !SYNC_POL;
            vga_vsync     <= !SYNC_POL;
            vga_rgb       <= '0;
        end else begin
            active_d      <= active;
            hs_d          <= hs_raw;
            vs_d          <= vs_raw;
            read_issued_d <= fifo_read;
            vga_hsync     <= hs_d ? SYNC_POL : !SYNC_POL;
            vga_vsync     <= vs_d ? SYNC_POL : !SYNC_POL;
            vga_rgb       <= (active_d && read_issued_d) ? fifo_dout : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            underflow <= 1'b0;
        end else if (state == IDLE && enable) begin
            underflow <= 1'b0;
        end else if (uf_event) begin
            underflow <= 1'b1;
        end
    end

`ifdef VGA_UNDERFLOW_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            underflow_cnt <= '0;
        end else if (state == IDLE && enable) begin
            underflow_cnt <= '0;
        end else if (uf_event && underflow_cnt != 16'hFFFF) begin
            underflow_cnt <= underflow_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vga_pixel_out.sv
// tb/tb_vga_pixel_out.sv - directed bench for vga_pixel_out on a reduced 15x10 raster
module tb_vga_pixel_out;

    localparam int RGB_W = 12;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             enable = 1'b0;
    logic             fifo_read;
    logic [RGB_W-1:0] fifo_dout = '0;
    logic             fifo_empty = 1'b0;
    logic             vga_hsync, vga_vsync;
    logic [RGB_W-1:0] vga_rgb;
    logic             frame_start;
    logic             underflow;
`ifdef VGA_UNDERFLOW_CNT_EN
    logic [15:0]      underflow_cnt;
`endif

    int errors = 0;
    int checks = 0;
    int ptr = 0;

    // H_TOTAL=15 (hsync h=10..12), V_TOTAL=10 (vsync v=7..8), frame=150 cycles
    vga_pixel_out #(
        .RGB_W(RGB_W), .H_DISPLAY(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_DISPLAY(6), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(1'b0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .fifo_read(fifo_read), .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
        .vga_hsync(vga_hsync), .vga_vsync(vga_vsync), .vga_rgb(vga_rgb),
        .frame_start(frame_start), .underflow(underflow)
`ifdef VGA_UNDERFLOW_CNT_EN
        , .underflow_cnt(underflow_cnt)
`endif
    );

    always #5 clk = ~clk;

    // FIFO read side: registered dout carrying an incrementing pattern
    always @(posedge clk) begin
        if (fifo_read) begin
            fifo_dout <= ptr[RGB_W-1:0];
            ptr       <= ptr + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_pos(input int h, input int v, input string tag);
        int n = 0;
        while (!(dut.h_cnt == h && dut.v_cnt == v) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(n < 1000), 32'd1);
    endtask

    logic rd_log [0:151];
    logic hs_log [0:151];
    logic vs_log [0:151];
    logic fs_log [0:151];
    logic [RGB_W-1:0] rgb_log [0:151];
    int cnt, n;
    logic [RGB_W-1:0] exp_pix [0:7];

    initial begin
        // Reset and IDLE
        repeat (3) @(negedge clk);
        check("rst_fifo_read", fifo_read, 0);
        check("rst_rgb", vga_rgb, 0);
        check("rst_hsync", vga_hsync, 1);
        check("rst_vsync", vga_vsync, 1);
        check("rst_frame_start", frame_start, 0);
        check("rst_underflow", underflow, 0);
        rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (fifo_read || vga_rgb != 0 || !vga_hsync || !vga_vsync || frame_start) cnt++;
        end
        check("idle_outputs_quiet", cnt, 0);
        check("idle_h_cnt", dut.h_cnt, 0);
        check("idle_v_cnt", dut.v_cnt, 0);

        // WAIT frame: no pops
        enable = 1'b1;
        n = 0;
        @(negedge clk);
        while (!frame_start && n < 500) begin @(negedge clk); n++; end
        check("wait_frame_start_seen", 32'(n < 500), 1);
        cnt = 0;
        for (int i = 0; i < 150; i++) begin
            if (fifo_read) cnt++;
            @(negedge clk);
        end
        check("wait_frame_no_pops", cnt, 0);
        check("run_first_frame_start", frame_start, 1);
        check("run_first_pop", fifo_read, 1);

        // First RUN frame, logged for alignment and sync timing
        for (int i = 0; i < 152; i++) begin
            rd_log[i] = fifo_read; hs_log[i] = vga_hsync; vs_log[i] = vga_vsync;
            fs_log[i] = frame_start; rgb_log[i] = vga_rgb;
            @(negedge clk);
        end
        check("pix_0_0", rgb_log[2], 12'h000);
        check("pix_7_0_last", rgb_log[9], 12'h007);
        check("pix_8_0_blank", rgb_log[10], 12'h000);
        check("pix_0_1", rgb_log[17], 12'h008);
        check("pix_7_5", rgb_log[2 + 5*15 + 7], 12'h02F);
        cnt = 0;
        for (int i = 0; i < 15; i++) if (rd_log[i]) cnt++;
        check("pops_line0", cnt, 8);
        cnt = 0;
        for (int i = 0; i < 150; i++) if (rd_log[i]) cnt++;
        check("pops_frame", cnt, 48);
        check("hsync_before", hs_log[11], 1);
        check("hsync_fall_at_12", hs_log[12], 0);
        check("hsync_last_low", hs_log[14], 0);
        check("hsync_rise", hs_log[15], 1);
        cnt = 0;
        for (int i = 2; i < 152; i++) if (!hs_log[i]) cnt++;
        check("hsync_low_cycles_frame", cnt, 30);
        check("vsync_before", vs_log[106], 1);
        check("vsync_fall", vs_log[107], 0);
        check("vsync_last_low", vs_log[136], 0);
        check("vsync_rise", vs_log[137], 1);
        cnt = 0;
        for (int i = 2; i < 152; i++) if (!vs_log[i]) cnt++;
        check("vsync_low_cycles_frame", cnt, 30);
        cnt = 0;
        for (int i = 0; i < 150; i++) if (fs_log[i]) cnt++;
        check("frame_start_once", cnt, 1);
        check("frame_start_period", fs_log[150], 1);

        // Underflow on pixels 2..5 of line 5 in the second RUN frame
        wait_pos(2, 5, "reach_underflow_point");
        exp_pix[0] = 12'd88; exp_pix[1] = 12'd89;
        exp_pix[2] = 12'd0;  exp_pix[3] = 12'd0;
        exp_pix[4] = 12'd0;  exp_pix[5] = 12'd0;
        exp_pix[6] = 12'd90; exp_pix[7] = 12'd91;
        for (int k = 0; k < 8; k++) begin
            fifo_empty = (k < 4);
            #1;
            check($sformatf("uf_rgb_pix%0d", k), vga_rgb, exp_pix[k]);
            check($sformatf("uf_read_h%0d", k + 2), fifo_read, (k == 4 || k == 5));
            @(negedge clk);
        end
        check("underflow_set", underflow, 1);
`ifdef VGA_UNDERFLOW_CNT_EN
        check("underflow_cnt", underflow_cnt, 4);
`endif

        // Disable mid-frame
        wait_pos(5, 3, "reach_disable_point");
        check("underflow_sticky", underflow, 1);
        enable = 1'b0;
        @(negedge clk);
        check("dis_fifo_read", fifo_read, 0);
        check("dis_h_cnt", dut.h_cnt, 0);
        check("dis_v_cnt", dut.v_cnt, 0);
        check("dis_state_idle", dut.state, 0);
        check("dis_frame_start", frame_start, 0);
        check("dis_underflow_kept", underflow, 1);

        // Re-enable: underflow clears, one full WAIT frame
        repeat (3) @(negedge clk);
        enable = 1'b1;
        @(negedge clk);
        check("reen_underflow_clear", underflow, 0);
`ifdef VGA_UNDERFLOW_CNT_EN
        check("reen_underflow_cnt_clear", underflow_cnt, 0);
`endif
        check("reen_frame_start", frame_start, 1);
        cnt = 0;
        for (int i = 0; i < 150; i++) begin
            if (fifo_read) cnt++;
            @(negedge clk);
        end
        check("reen_wait_no_pops", cnt, 0);
        check("reen_first_pop", fifo_read, 1);

        // Asynchronous reset between edges during RUN
        repeat (19) @(negedge clk);
        check("pre_reset_reading", fifo_read, 1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("areset_fifo_read", fifo_read, 0);
        check("areset_rgb", vga_rgb, 0);
        check("areset_hsync", vga_hsync, 1);
        check("areset_vsync", vga_vsync, 1);
        check("areset_frame_start", frame_start, 0);
        check("areset_h_cnt", dut.h_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
